// File: rtl/lpf_pkg.sv
// Shared types and helpers for the FIR decimation stage and its downstream FFT stage.
package lpf_pkg;

    // Default widths shared with the pitch-detection/FFT stage.
    localparam int LPF_IN_WIDTH   = 32;
    localparam int LPF_OUT_WIDTH  = 16;
    localparam int LPF_SHIFT      = 8;
    localparam int LPF_DECIM      = 8;
    localparam int LPF_FIFO_DEPTH = 4;

    typedef logic signed [LPF_OUT_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t value;
        logic    sat;
    } sat_shift_t;

    // Output sample range expressed at the input width, for comparisons.
    localparam logic signed [LPF_IN_WIDTH-1:0] SAMPLE_MAX =
        {{(LPF_IN_WIDTH - LPF_OUT_WIDTH + 1){1'b0}}, {(LPF_OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [LPF_IN_WIDTH-1:0] SAMPLE_MIN =
        {{(LPF_IN_WIDTH - LPF_OUT_WIDTH + 1){1'b1}}, {(LPF_OUT_WIDTH - 1){1'b0}}};

    // Sign-preserving right shift followed by clamping to the sample range.
    function automatic sat_shift_t sat_shift(input logic signed [LPF_IN_WIDTH-1:0] din,
                                             input int shift);
        logic signed [LPF_IN_WIDTH-1:0] y;
        sat_shift_t res;
        y = din >>> shift;
        if (y > SAMPLE_MAX) begin
            res.value = SAMPLE_MAX[LPF_OUT_WIDTH-1:0];
            res.sat   = 1'b1;
        end else if (y < SAMPLE_MIN) begin
            res.value = SAMPLE_MIN[LPF_OUT_WIDTH-1:0];
            res.sat   = 1'b1;
        end else begin
            res.value = y[LPF_OUT_WIDTH-1:0];
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/lpf_decimator_fifo.sv
// Small synchronous FIFO holding decimated samples. The head entry is read straight
// from the storage registers, so data_o never has a combinational path from push.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CNT_FULL) || pop_ok);

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign count_o = count_q;

    // Next-state: write at the tail, advance pointers (power-of-two wrap), track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the FIFO and zeroes storage so the head reads 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lpf_decimator.sv
// Decimator behind the FIR low-pass filter: keeps one accepted beat in DECIM, scales and
// saturates it, and buffers it for an AXI-stream consumer. The FIR has no tready, so
// backpressure is absorbed by the FIFO and overflow is reported on a sticky flag.
// Timing: a kept beat sampled at one edge lands in the stage register, pushes into the
// FIFO at the following edge, and is visible as m_tvalid right after that push.
module lpf_decimator
    import lpf_pkg::*;
#(
    parameter int IN_WIDTH   = LPF_IN_WIDTH,
    parameter int OUT_WIDTH  = LPF_OUT_WIDTH,
    parameter int SHIFT      = LPF_SHIFT,
    parameter int DECIM      = LPF_DECIM,
    parameter int FIFO_DEPTH = LPF_FIFO_DEPTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          s_tvalid,
    input  logic [IN_WIDTH-1:0]           s_tdata,
    output logic                          m_tvalid,
    output logic [OUT_WIDTH-1:0]          m_tdata,
    input  logic                          m_tready,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]      phase_q, phase_d;
    logic                 stage_valid_q, stage_valid_d;
    logic [OUT_WIDTH-1:0] stage_data_q, stage_data_d;
    logic                 sat_q, sat_d;
    logic                 ovf_q, ovf_d;
    logic                 keep;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    sat_shift_t           scaled;

    // Only accepted beats advance the phase; idle cycles leave it alone.
    assign keep   = s_tvalid && (phase_q == '0);
    assign scaled = sat_shift(s_tdata, SHIFT);
    assign pop    = m_tvalid && m_tready;

    // Next-state for phase, stage register and the sticky status flags.
    always_comb begin
        phase_d = phase_q;
        if (s_tvalid) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        end
        stage_valid_d = keep;
        stage_data_d  = keep ? scaled.value : stage_data_q;
        sat_d         = sat_q | (keep & scaled.sat);
        // A stage push into a full FIFO is lost unless the head pops in the same cycle.
        ovf_d         = ovf_q | (stage_valid_q & fifo_full & ~pop);
    end

    // Phase, stage and flag registers; reset restarts at phase 0 so the next beat is kept.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            phase_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            sat_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            sat_q         <= sat_d;
            ovf_q         <= ovf_d;
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (stage_valid_q),
        .data_i  (stage_data_q),
        .pop_i   (pop),
        .data_o  (m_tdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_level)
    );

    assign m_tvalid = ~fifo_empty;
    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

endmodule
